// File: rtl/fir_pkg.sv
// Shared constants and sample types for the FIR output conditioning stage.
// Latency: none (package only).
// Backpressure: not applicable.
//
// Holds the Q4.18 input and Q2.10 output formats, the round-half-up constant
// for the 8-bit requantizing shift, and the output clamp limits.
package fir_pkg;

    localparam int IN_W     = 22;
    localparam int IN_FRAC  = 18;
    localparam int OUT_W    = 12;
    localparam int OUT_FRAC = 10;

    // Fraction bits dropped by requantization.
    localparam int SHIFT    = IN_FRAC - OUT_FRAC;
    // Half an output LSB, expressed in input LSBs.
    localparam int RND      = 1 << (IN_FRAC - OUT_FRAC - 1);

    localparam int OUT_MAX  = (1 << (OUT_W - 1)) - 1;
    localparam int OUT_MIN  = -(1 << (OUT_W - 1));

    typedef logic signed [IN_W-1:0]  in_sample_t;
    typedef logic signed [OUT_W-1:0] out_sample_t;

endpackage

// File: rtl/fir_out_decim_if.sv
// Output stream bundle: Q2.10 sample with a valid/ready handshake.
// Latency: none (wiring only).
// Backpressure: the slave holds off the master by keeping out_ready low.
//
// master: drives out_data/out_valid, samples out_ready.
// slave : samples out_data/out_valid, drives out_ready.
interface fir_out_decim_if #(
    parameter int OUT_W = fir_pkg::OUT_W
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous circular-buffer FIFO with push/pop, full/empty and level.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: a push while full is accepted only if a pop happens the same cycle.
//
// Ports: clk, rstn (sync, active-low); push_vld_i/push_dat_i write side;
// pop_rdy_i consumer ready; head_dat_o (0 when empty), empty_o, full_o, level_o.
module fir_out_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_vld_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_rdy_i,
    output logic [W-1:0]               head_dat_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push, pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop     = pop_rdy_i & ~empty_o;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push    = push_vld_i & (~full_o | pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // Forced to zero when empty so the head is well defined after reset.
    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o    = cnt_q;

endmodule

// File: rtl/fir_out_decim.sv
// FIR output conditioning: decimate by DECIM, requantize Q4.18 -> Q2.10 (round half up), buffer.
// Latency: 2 cycles from a kept input sample to out_valid (one requant register + FIFO).
// Backpressure: out_ready stalls the FIFO; kept samples arriving while full are dropped (drop_flag).
//
// Ports: clk, rstn (sync, active-low); in_data/in_valid filter result; phase_clr restarts the
// decimation phase; out_if (master) carries out_data/out_valid/out_ready; fifo_level occupancy;
// drop_flag and sat_flag are sticky until reset.
// Build option: define FIR_OUT_SAT_EN to clamp out-of-range results and enable sat_flag;
// otherwise results wrap to OUT_W bits and sat_flag is constant 0.
module fir_out_decim #(
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int IN_W       = fir_pkg::IN_W,
    parameter int OUT_W      = fir_pkg::OUT_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic signed [IN_W-1:0]        in_data,
    input  logic                          in_valid,
    input  logic                          phase_clr,
    fir_out_decim_if.master               out_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          drop_flag,
    output logic                          sat_flag
);
    import fir_pkg::*;

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = IN_W + 1;

    // ---------------- decimation ----------------
    logic [PW-1:0] phase_q, phase_d, phase_eff;
    logic          keep;

    always_comb begin
        // phase_clr makes this cycle behave as phase 0, then counting resumes from it.
        phase_eff = phase_clr ? '0 : phase_q;
        keep      = in_valid && (phase_eff == '0);
        phase_d   = phase_eff;
        if (in_valid) begin
            phase_d = (phase_eff == PW'(DECIM - 1)) ? '0 : phase_eff + PW'(1);
        end
    end

    // ---------------- requantize ----------------
    logic signed [TW-1:0] sum, t;
    logic [OUT_W-1:0]     q_d;

    // One extra bit keeps the rounding add from overflowing at full scale.
    assign sum = {in_data[IN_W-1], in_data} + TW'(RND);
    assign t   = sum >>> SHIFT;

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [TW-1:0] T_MAX = TW'(OUT_MAX);
    localparam logic signed [TW-1:0] T_MIN = TW'(OUT_MIN);
    localparam logic [OUT_W-1:0]     O_MAX = OUT_W'(OUT_MAX);
    localparam logic [OUT_W-1:0]     O_MIN = OUT_W'(OUT_MIN);

    logic sat_now;
    logic sat_q;

    always_comb begin
        sat_now = 1'b0;
        q_d     = t[OUT_W-1:0];
        if (t > T_MAX) begin
            sat_now = 1'b1;
            q_d     = O_MAX;
        end else if (t < T_MIN) begin
            sat_now = 1'b1;
            q_d     = O_MIN;
        end
    end

    // Only samples that survive decimation can raise the flag.
    always_ff @(posedge clk) begin
        if (!rstn) sat_q <= 1'b0;
        else       sat_q <= sat_q | (keep & sat_now);
    end

    assign sat_flag = sat_q;
`else
    logic unused_t_hi;

    // Two's-complement wrap: high bits of t are intentionally discarded.
    assign q_d         = t[OUT_W-1:0];
    assign unused_t_hi = ^t[TW-1:OUT_W];
    assign sat_flag    = 1'b0;
`endif

    // ---------------- requant register ----------------
    logic [OUT_W-1:0] q_reg_q;
    logic             q_vld_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_q <= '0;
            q_vld_q <= 1'b0;
            q_reg_q <= '0;
        end else begin
            phase_q <= phase_d;
            q_vld_q <= keep;
            if (keep) q_reg_q <= q_d;
        end
    end

    // ---------------- output FIFO ----------------
    logic fifo_empty, fifo_full;
    logic drop_q;

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_vld_i (q_vld_q),
        .push_dat_i (q_reg_q),
        .pop_rdy_i  (out_if.out_ready),
        .head_dat_o (out_if.out_data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .level_o    (fifo_level)
    );

    // out_valid is a pure function of occupancy, never of out_ready.
    assign out_if.out_valid = ~fifo_empty;

    // A sample is lost only when full and the consumer is not draining this cycle.
    always_ff @(posedge clk) begin
        if (!rstn) drop_q <= 1'b0;
        else       drop_q <= drop_q | (q_vld_q & fifo_full & ~out_if.out_ready);
    end

    assign drop_flag = drop_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim: three instances (DECIM = 1, 2, 4) share stimulus.
// Latency: expectations assume 2 cycles from kept sample to out_valid.
// Backpressure: exercised by holding out_ready low to fill the FIFO.
module tb_fir_out_decim;
    import fir_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, in_valid, phase_clr, out_ready;
    in_sample_t in_data;

    always #5 clk = ~clk;

    fir_out_decim_if #(.OUT_W(12)) if1 ();
    fir_out_decim_if #(.OUT_W(12)) if2 ();
    fir_out_decim_if #(.OUT_W(12)) if4 ();

    assign if1.out_ready = out_ready;
    assign if2.out_ready = out_ready;
    assign if4.out_ready = out_ready;

    logic [2:0] lvl1, lvl2, lvl4;
    logic       drop1, drop2, drop4, sat1, sat2, sat4;

    fir_out_decim #(.DECIM(1), .FIFO_DEPTH(4), .IN_W(22), .OUT_W(12)) dut1 (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .phase_clr(phase_clr),
        .out_if(if1), .fifo_level(lvl1), .drop_flag(drop1), .sat_flag(sat1));
    fir_out_decim #(.DECIM(2), .FIFO_DEPTH(4), .IN_W(22), .OUT_W(12)) dut2 (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .phase_clr(phase_clr),
        .out_if(if2), .fifo_level(lvl2), .drop_flag(drop2), .sat_flag(sat2));
    fir_out_decim #(.DECIM(4), .FIFO_DEPTH(4), .IN_W(22), .OUT_W(12)) dut4 (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .phase_clr(phase_clr),
        .out_if(if4), .fifo_level(lvl4), .drop_flag(drop4), .sat_flag(sat4));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        phase_clr = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    logic [21:0] rv   [6];
    logic [11:0] rexp [6];
    logic        exp_v;
    logic [11:0] exp_d;

    initial begin
        in_data   = '0;
        out_ready = 1'b1;
        do_reset();

        // ---- reset state ----
        check("rst_valid", 32'(if1.out_valid), 32'd0);
        check("rst_data",  32'(if1.out_data),  32'h000);
        check("rst_level", 32'(lvl1),          32'd0);
        check("rst_drop",  32'(drop1),         32'd0);
        check("rst_sat",   32'(sat1),          32'd0);
        check("rst_level4", 32'(lvl4),         32'd0);

        // ---- DECIM=2, constant 1.0 input ----
        in_valid = 1'b1;
        in_data  = 22'h040000;
        for (int s = 1; s <= 6; s++) begin
            step();
            check($sformatf("d2_valid_%0d", s), 32'(if2.out_valid), 32'((s % 2) == 0));
            if ((s % 2) == 0) check($sformatf("d2_data_%0d", s), 32'(if2.out_data), 32'h400);
        end

        // ---- rounding / wrap or saturation at DECIM=1, full throughput ----
        do_reset();
        rv[0] = 22'h000080; rexp[0] = 12'h001;
        rv[1] = 22'h00007F; rexp[1] = 12'h000;
        rv[2] = 22'h3FFF80; rexp[2] = 12'h000;
        rv[3] = 22'h3FFF7F; rexp[3] = 12'hFFF;
        rv[4] = 22'h0C0000;
        rv[5] = 22'h340000;
`ifdef FIR_OUT_SAT_EN
        rexp[4] = 12'h7FF;
        rexp[5] = 12'h800;
`else
        rexp[4] = 12'hC00;
        rexp[5] = 12'h400;
`endif
        for (int j = 0; j < 8; j++) begin
            in_valid = (j < 6);
            in_data  = rv[(j < 6) ? j : 0];
            step();
            if (j >= 1 && j <= 6) begin
                check($sformatf("rnd_valid_%0d", j), 32'(if1.out_valid), 32'd1);
                check($sformatf("rnd_data_%0d", j),  32'(if1.out_data),  32'(rexp[j-1]));
            end
            if (j == 7) check("rnd_drained", 32'(if1.out_valid), 32'd0);
        end
`ifdef FIR_OUT_SAT_EN
        check("sat_flag", 32'(sat1), 32'd1);
`else
        check("sat_flag", 32'(sat1), 32'd0);
`endif

        // ---- backpressure: 8 samples into a 4-deep FIFO ----
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 22'((k + 1) << 8);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("bp_level", 32'(lvl1),          32'd4);
        check("bp_drop",  32'(drop1),         32'd1);
        check("bp_valid", 32'(if1.out_valid), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_drain_valid_%0d", k), 32'(if1.out_valid), 32'd1);
            check($sformatf("bp_drain_data_%0d", k),  32'(if1.out_data),  32'(k + 1));
            step();
        end
        check("bp_empty_valid", 32'(if1.out_valid), 32'd0);
        check("bp_empty_level", 32'(lvl1),          32'd0);

        // ---- DECIM=4 with phase_clr at phase 2 ----
        do_reset();
        out_ready = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            in_valid  = 1'b1;
            phase_clr = (s == 3);
            in_data   = (s == 3) ? 22'h020000 : 22'(s << 8);
            step();
            exp_v = (s == 2) || (s == 4) || (s == 8);
            exp_d = (s == 2) ? 12'h001 : (s == 4) ? 12'h200 : 12'h007;
            check($sformatf("pc_valid_%0d", s), 32'(if4.out_valid), 32'(exp_v));
            if (exp_v) check($sformatf("pc_data_%0d", s), 32'(if4.out_data), 32'(exp_d));
        end
        phase_clr = 1'b0;
        in_valid  = 1'b0;

        // ---- reset mid-operation with level 3 and drop set ----
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 22'h010000;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("mid_level_pre", 32'(lvl1),  32'd3);
        check("mid_drop_pre",  32'(drop1), 32'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("mid_valid", 32'(if1.out_valid), 32'd0);
        check("mid_level", 32'(lvl1),          32'd0);
        check("mid_drop",  32'(drop1),         32'd0);
        check("mid_data",  32'(if1.out_data),  32'h000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fir_out_decim.md
# fir_out_decim

Output conditioning stage placed directly downstream of the 5-tap direct-form FIR. Consumes the filter's full-precision Q4.18 result, decimates by a programmable factor, and requantizes to Q2.10 with round-half-up and optional saturation. Buffers results in a small FIFO and hands them to the next consumer over a valid/ready handshake.

## Interface
Parameters:
- DECIM, 2: decimation factor, 1..16. 1 keeps every valid sample.
- FIFO_DEPTH, 4: output FIFO entries, power of two, 2..16.
- IN_W, 22: input width, Q4.18.
- OUT_W, 12: output width, Q2.10.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_data  in  IN_W  signed filter output, Q4.18.
- in_valid  in  1  in_data valid this cycle. Tie high when the filter runs every clock.
- phase_clr  in  1  synchronous restart of the decimation phase.
- out_data  out  OUT_W  signed Q2.10 sample at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_flag  out  1  sticky: a kept sample was lost because the FIFO was full.
- sat_flag  out  1  sticky: a saturation event occurred.

## Operation
Decimation:
- Phase counter runs 0..DECIM-1 and advances on each in_valid, wrapping to 0.
- A sample is kept when in_valid=1 and phase=0.
- phase_clr=1 forces the phase to 0 for the current cycle's decision, so a valid sample in that cycle is kept. The counter is 1 on the next cycle (0 if DECIM=1). phase_clr takes precedence over normal advance.

Requantize (one pipeline register, q_reg/q_vld):
- Compute t = (in_data + 2^7) >>> 8 in IN_W+1 bits.
- Rounding is half-up toward +inf: 0x000080 gives 1; 0x3FFF80 gives 0.
- Saturate t to [-2048, 2047]; see Configuration.

FIFO:
- Circular buffer with read/write pointers and a count.
- Write occurs when q_vld=1 and (count<FIFO_DEPTH, or a pop happens in the same cycle).
- If full with no pop, the sample is discarded, drop_flag is set, and the FIFO is unchanged.
- Pop occurs when out_valid && out_ready.
- Simultaneous push and pop leaves count unchanged; pointers both advance and wrap modulo FIFO_DEPTH.
- There is no empty bypass: a write into an empty FIFO makes out_valid visible on the next cycle.
- out_data is read combinationally from the head entry and holds stable while out_valid=1 and out_ready=0.
- drop_flag and sat_flag clear only on reset.

Reset:
- Takes effect on the first clk edge with rstn=0 and overrides all other inputs.
- Phase=0, q_vld=0, pointers=0, count=0.
- Outputs after reset: out_valid=0, out_data=0, fifo_level=0, drop_flag=0, sat_flag=0.
- Reset mid-operation discards FIFO contents and any in-flight sample.

## Timing
- Kept sample presented in cycle n → q_reg loads at edge n → FIFO write at edge n+1 → out_valid=1 in cycle n+2 (FIFO previously empty). Latency is 2 cycles.
- Throughput: one sample per cycle at DECIM=1 with out_ready held high.
- fifo_level and the flags update on the same edge as the event that changes them.
- The out_valid/ready handshake follows AXI-stream rules. out_valid must not depend combinationally on out_ready.

## Configuration
- FIR_OUT_SAT_EN defined: values outside [-2048, 2047] clamp to 0x7FF or 0x800, and sat_flag is set.
- FIR_OUT_SAT_EN undefined: the low OUT_W bits of t are taken (two's-complement wrap). sat_flag is tied to 0 and the saturation logic is absent.

## Structure
- Shared package fir_pkg holds:
  - widths and fractional bits: IN_W=22, IN_FRAC=18, OUT_W=12, OUT_FRAC=10;
  - rounding constant RND = 1<<(IN_FRAC-OUT_FRAC-1);
  - OUT_MAX and OUT_MIN;
  - sample typedefs.
- One sub-module: fir_out_fifo, a parameterized synchronous FIFO with push/pop, full/empty and level.
- Decimation and requantize logic live in the top level.

## Test plan
- DECIM=2, in_valid=1, in_data=0x040000 (1.0), out_ready=1 → out_data=0x400 on every second cycle; first out_valid 2 cycles after the first kept sample.
- Rounding, DECIM=1:
  - 0x000080 → 0x001;
  - 0x00007F → 0x000;
  - 0x3FFF80 → 0x000;
  - 0x3FFF7F → 0xFFF.
- Saturation with FIR_OUT_SAT_EN: 0x0C0000 → 0x7FF and 0x340000 → 0x800, with sat_flag=1. Without the macro: 0x0C0000 → 0xC00 and sat_flag=0.
- Backpressure, DECIM=1, FIFO_DEPTH=4: out_ready=0 for 8 distinct samples → fifo_level=4 and drop_flag=1. Then out_ready=1 → the first 4 samples appear in order, then out_valid=0.
- DECIM=4: assert phase_clr with sample 0x020000 at phase 2 → that sample is kept (out 0x200). The next kept sample is 4 valid cycles later.
- rstn=0 for one cycle with fifo_level=3 and drop_flag=1 → next cycle out_valid=0, fifo_level=0, drop_flag=0, out_data=0.
